// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with open-drain clock/data enables.
// Define PS2_HOST_TX_TIMEOUT_EN to build the watchdog that aborts a transfer from a silent device.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err_timeout
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE, DONE} state_t;

    if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("ps2_host_tx: cycle parameters must be at least 1");
    end

    state_t        state_q, state_d;
    logic [2:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic [3:0]    bit_q, bit_d;
    logic [IW-1:0] inh_q, inh_d;
    logic          ack_int_q, ack_int_d;
    logic          data_oe_q, data_oe_d;
    logic          tx_ready_q, clk_oe_q, busy_q, done_q, ack_q;
    logic          fall, tmo_hit;

    // clk_sync_q: [0] first stage, [1] synchronised level, [2] previous level
    assign fall = clk_sync_q[2] & ~clk_sync_q[1];

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_d     = par_q;
        bit_d     = bit_q;
        inh_d     = inh_q;
        ack_int_d = ack_int_q;
        data_oe_d = data_oe_q;
        case (state_q)
            IDLE: if (tx_valid && tx_ready_q) begin
                data_d    = tx_data;
                par_d     = ~^tx_data;
                inh_d     = '0;
                data_oe_d = 1'b0;
                state_d   = INHIBIT;
            end
            INHIBIT: if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
                data_oe_d = 1'b1;
                state_d   = REQ;
            end else begin
                inh_d = inh_q + 1'b1;
            end
            REQ: begin
                bit_d   = 4'd0;
                state_d = SHIFT;
            end
            SHIFT: if (fall) begin
                bit_d     = bit_q + 4'd1;
                data_oe_d = (bit_q == 4'd9) ? 1'b0 : (bit_q == 4'd8) ? ~par_q : ~data_q[bit_q[2:0]];
                state_d   = (bit_q == 4'd9) ? ACK : SHIFT;
            end
            ACK: if (fall) begin
                ack_int_d = ~dat_sync_q[1];
                state_d   = WAIT_IDLE;
            end
            WAIT_IDLE: if (clk_sync_q[1] && dat_sync_q[1]) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (tmo_hit) begin
            data_oe_d = 1'b0;
            ack_int_d = 1'b0;
            state_d   = DONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            data_q     <= '0;
            par_q      <= 1'b0;
            bit_q      <= '0;
            inh_q      <= '0;
            ack_int_q  <= 1'b0;
            data_oe_q  <= 1'b0;
            tx_ready_q <= 1'b1;
            clk_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            data_q     <= data_d;
            par_q      <= par_d;
            bit_q      <= bit_d;
            inh_q      <= inh_d;
            ack_int_q  <= ack_int_d;
            data_oe_q  <= data_oe_d;
            tx_ready_q <= state_d == IDLE;
            clk_oe_q   <= state_d inside {INHIBIT, REQ};
            busy_q     <= state_d != IDLE;
            done_q     <= state_d == DONE;
            ack_q      <= (state_d == DONE) ? ack_int_d : ack_q;
        end
    end

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    logic          err_q;
    logic          tmo_en;

    assign tmo_en  = state_q inside {REQ, SHIFT, ACK, WAIT_IDLE};
    assign tmo_hit = tmo_en && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= (state_q == INHIBIT) ? '0 : tmo_en ? tmo_q + 1'b1 : tmo_q;
            err_q <= (state_d == DONE) ? tmo_hit : err_q;
        end
    end

    assign err_timeout = err_q;
`else
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign tx_ready    = tx_ready_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ack_ok      = ack_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a behavioural PS/2 keyboard model on an open-drain bus.
// Frames are predicted from the byte alone (data LSB first, odd parity, stop) and compared bit by bit.
module tb_ps2_host_tx;
    localparam int INH = 40;
    localparam int TMO = 1000;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, err_timeout;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       pin_clk, pin_data;
    int         tests = 0;
    int         fails = 0;
    int         done_cnt = 0;

    assign pin_clk  = dev_clk & ~ps2_clk_oe;
    assign pin_data = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk(pin_clk), .ps2_data(pin_data), .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .busy(busy), .done(done), .ack_ok(ack_ok), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt++;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
        $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
    end

    typedef struct {
        logic [7:0] d;
        bit         ack;
        bit         par;
        bit         exp_ack;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference frame: bits[7:0] data, bits[8] odd parity, bits[9] stop
    function automatic logic [9:0] frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2) == 0, d};
    endfunction

    task automatic pulse(output logic samp);
        repeat (8) @(negedge clk);
        dev_clk = 1'b0;
        repeat (8) @(negedge clk);
        samp = pin_data;
        dev_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] d);
        int k = 0;
        while (!tx_ready && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("tx_ready_before_send", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic device(input bit ack, input int hold, output logic [9:0] bits, output int low);
        int   k = 0;
        int   dc;
        logic dummy;
        low = 0;
        while (!ps2_clk_oe && k < 100) begin
            @(negedge clk);
            k++;
        end
        while (ps2_clk_oe && low < 20000) begin
            low++;
            @(negedge clk);
        end
        check("start_bit_driven", ps2_data_oe, 1);
        for (int i = 0; i < 10; i++) pulse(bits[i]);
        dc = done_cnt;
        if (ack) dev_data = 1'b0;
        pulse(dummy);
        repeat (hold) @(negedge clk);
        if (hold > 0) check("no_done_while_data_low", done_cnt, dc);
        dev_data = 1'b1;
        k = 0;
        while (done_cnt == dc && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("done_pulse_seen", done_cnt, dc + 1);
    endtask

    task automatic run(input logic [7:0] d, input bit ack, input int hold, output logic [9:0] b);
        logic [9:0] e;
        int         low;
        send(d);
        device(ack, hold, b, low);
        e = frame(d);
        check("clock_low_cycles", low, INH + 1);
        check("data_bits", b[7:0], e[7:0]);
        check("parity_bit", b[8], e[8]);
        check("stop_bit", b[9], 1);
        check("ack_ok", ack_ok, ack);
        check("err_timeout", err_timeout, 0);
    endtask

    initial begin
        vec_t       tbl[4];
        logic [9:0] b;
        int         low, k, n, dc;
        tbl = '{'{8'hED, 1'b1, 1'b1, 1'b1}, '{8'hF4, 1'b0, 1'b0, 1'b0},
                '{8'h00, 1'b1, 1'b1, 1'b1}, '{8'h80, 1'b0, 1'b0, 1'b0}};

        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_ok", ack_ok, 0);
        check("rst_err_timeout", err_timeout, 0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run(tbl[i].d, tbl[i].ack, 0, b);
            check("table_parity", b[8], tbl[i].par);
            check("table_ack", ack_ok, tbl[i].exp_ack);
            check("table_idle_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        end

        for (int i = 0; i < 6; i++) run(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0, b);

        run(8'hA5, 1'b1, 200, b);

        // tx_valid held high: 0x55 must wait for the 0xFF transfer to finish
        send(8'hFF);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        device(1'b1, 0, b, low);
        check("held_first_byte", b[7:0], 8'hFF);
        check("held_ready_after_done", tx_ready, 1);
        @(negedge clk);
        check("held_accepted", busy, 1);
        tx_valid = 1'b0;
        device(1'b1, 0, b, low);
        check("held_second_byte", b[7:0], 8'h55);
        check("held_second_low", low, INH + 1);

        // Reset after the fourth falling edge of a 0x30 transfer
        send(8'h30);
        k = 0;
        while (ps2_clk_oe && k < 1000) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 4; i++) pulse(b[i]);
        check("pre_reset_data_oe", ps2_data_oe, 1);
        dc = done_cnt;
        #2 rstn = 1'b0;
        #1;
        check("reset_clk_oe_async", ps2_clk_oe, 0);
        check("reset_data_oe_async", ps2_data_oe, 0);
        check("reset_busy_async", busy, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx_ready", tx_ready, 1);
        repeat (50) @(negedge clk);
        check("reset_no_done", done_cnt, dc);
        run(8'hC3, 1'b1, 0, b);

`ifdef PS2_HOST_TX_TIMEOUT_EN
        send(8'hAA);
        k = 0;
        while (!(ps2_clk_oe && ps2_data_oe) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("tmo_req_seen", ps2_clk_oe && ps2_data_oe, 1);
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("tmo_done_delay", n, TMO);
        check("tmo_err", err_timeout, 1);
        check("tmo_ack", ack_ok, 0);
        check("tmo_oes", {ps2_clk_oe, ps2_data_oe}, 0);
        @(negedge clk);
        run(8'h0F, 1'b1, 0, b);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
